regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Shares the single register-file write port between the in-order writeback stage and a long-latency result source, such as a multi-cycle multiply/divide unit or a late load return. The long-latency source is buffered in a 2-entry FIFO. The block sits between writeback/execute and the register file and drives the port's `wr_addr`/`wr_data`/`wr_enable` from registers. A starvation counter guarantees forward progress for buffered results, and a hazard output lets decode stall on registers whose write is still pending.

## Interface
Parameters:
- `XLEN`, 32: register data width.
- `AW`, 5: register address width.
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may lose before it is forced to win; legal range 1–15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; the block is in reset while `reset`==0.
- `wb_valid` in 1: writeback stage presents a register write.
- `wb_addr` in AW: destination register.
- `wb_data` in XLEN: write data.
- `wb_ready` out 1: writeback write accepted this cycle; when low, the pipeline holds the writeback stage.
- `lt_valid` in 1: long-latency result valid.
- `lt_addr` in AW: destination register.
- `lt_data` in XLEN: result data.
- `lt_ready` out 1: FIFO can accept; the transfer happens when `lt_valid`&&`lt_ready`.
- `rs1_addr` in AW: decode source register 1.
- `rs2_addr` in AW: decode source register 2.
- `hazard` out 1: a FIFO entry targets a nonzero `rs1_addr`/`rs2_addr`.
- `pending` out 2: FIFO occupancy, 0–2.
- `wr_addr` out AW: register-file write address (registered).
- `wr_data` out XLEN: register-file write data (registered).
- `wr_enable` out 1: register-file write strobe (registered).

## Operation
- **FIFO:** 2 entries of {addr, data}, with head pointer, tail pointer and a 2-bit count.
  - `lt_ready` = (count < 2), combinational from state only.
  - Push when `lt_valid`&&`lt_ready`. No pass-through: a pushed entry is eligible to be granted from the next cycle.
- **Grant, evaluated each cycle:**
  - FIFO wins if count>0 and (`wb_valid`==0 or starve_cnt==STARVE_LIMIT).
  - Otherwise writeback wins if `wb_valid`.
  - Otherwise the port is idle.
- **`wb_ready`:** 1 unless the FIFO wins while `wb_valid`==1. With `wb_valid`==0, `wb_ready`=1; this is don't-care for the stage.
- **starve_cnt (4-bit):**
  - Cleared when the FIFO pops or count==0.
  - Incremented when count>0 and writeback wins.
  - Saturates at STARVE_LIMIT.
- **Simultaneous push and pop:** allowed when count==1 (count stays 1) and when count==2 (pop only; `lt_ready` was 0).
- **x0 writes:** a granted write with addr==0 is consumed (FIFO pops, or `wb_ready`=1), but `wr_enable` stays 0 next cycle.
- **hazard:** combinational. It is the OR over valid entries of (entry.addr!=0 && (entry.addr==`rs1_addr` || entry.addr==`rs2_addr`)). The entry being popped this cycle still counts.
- **Ordering:** the arbiter does not reorder same-rd writes. Decode must use `hazard` so that no writeback instruction targets an rd that is pending in the FIFO.
- **`pending`:** equals count.

## Timing
- **Reset (async assert):** `wr_enable`=0, `wr_addr`=0, `wr_data`=0, count=0, pointers=0, starve_cnt=0. FIFO contents are discarded.
  - Therefore `lt_ready`=1, `hazard`=0 and `pending`=0 during reset.
  - Deassertion is synchronous to `clk`, as handled by the reset synchronizer upstream.
- **Latency:** a write granted in cycle N appears on `wr_*` in cycle N+1, with `wr_enable` high for exactly one cycle.
- **Back-to-back grants:** produce consecutive `wr_enable` pulses with no bubble.
- **Minimum lt latency:** push in cycle N; earliest grant in cycle N+1; `wr_enable` in cycle N+2.
- **Starvation bound:** with `wb_valid` held high, a FIFO head waits at most STARVE_LIMIT cycles before its grant cycle.
- **Reset mid-operation:** pending FIFO entries are lost, and any write in flight on `wr_*` is dropped.

## Test plan
- **Writeback only:** reset released, `wb_valid`=1 with addr=5, data=0xDEADBEEF for 1 cycle → next cycle `wr_enable`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF; `wb_ready`=1 throughout.
- **lt only:** `lt_valid` with addr=7, data=0x12345678 in cycle 0, `wb_valid`=0 → `pending`=1 in cycle 1, grant in cycle 1, `wr_enable` with addr 7 in cycle 2, `pending`=0 in cycle 2.
- **Starvation** (STARVE_LIMIT=4): one lt push, then `wb_valid` held high with addrs 1,2,3,… → four writeback writes, then `wb_ready`=0 for exactly one cycle, the FIFO write appears on `wr_*` the cycle after, and writeback resumes with the held write.
- **Full FIFO:** two lt pushes while `wb_valid`=1 continuously → `lt_ready`=0 and `pending`=2; a third `lt_valid` is not accepted; after the forced pop, `lt_ready` returns to 1.
- **Hazard and x0:** FIFO holds addr=9, `rs2_addr`=9 → `hazard`=1; `rs1_addr`=`rs2_addr`=0 with an entry addr=0 → `hazard`=0; granting the addr=0 entry pops it with no `wr_enable`.
- **Async reset:** assert `reset`=0 mid-cycle with `pending`=2 → immediately `pending`=0, `wr_enable`=0, `lt_ready`=1, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between writeback and a
// 2-entry FIFO of long-latency results, with a starvation bound and a decode hazard.
module regfile_wr_arbiter #(
    parameter int XLEN = 32,
    parameter int AW = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lt_valid,
    input  logic [AW-1:0]   lt_addr,
    input  logic [XLEN-1:0] lt_data,
    output logic            lt_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            hazard,
    output logic [1:0]      pending,
    output logic [AW-1:0]   wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            wr_enable
);
    logic [AW-1:0]   fifo_addr [2];
    logic [XLEN-1:0] fifo_data [2];
    logic            head, tail;
    logic [1:0]      count;
    logic [3:0]      starve;
    logic            push, pop, wb_win, grant;
    logic [AW-1:0]   g_addr;
    logic [XLEN-1:0] g_data;
    logic [1:0]      vld;

    always_comb begin
        lt_ready = count != 2'd2;
        push     = lt_valid && lt_ready;
        pop      = count != 2'd0 && (!wb_valid || starve == 4'(STARVE_LIMIT));
        wb_win   = wb_valid && !pop;
        wb_ready = !(pop && wb_valid);
        grant    = pop || wb_win;
        g_addr   = pop ? fifo_addr[head] : wb_addr;
        g_data   = pop ? fifo_data[head] : wb_data;
        pending  = count;
        vld[0]   = count == 2'd2 || (count == 2'd1 && !head);
        vld[1]   = count == 2'd2 || (count == 2'd1 && head);
        hazard   = 1'b0;
        for (int i = 0; i < 2; i++)
            hazard = hazard || (vld[i] && fifo_addr[i] != '0 &&
                     (fifo_addr[i] == rs1_addr || fifo_addr[i] == rs2_addr));
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk)
        if (push) begin
            fifo_addr[tail] <= lt_addr;
            fifo_data[tail] <= lt_data;
        end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            starve    <= 4'd0;
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (push) tail <= !tail;
            if (pop) head <= !head;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop || count == 2'd0) starve <= 4'd0;
            else if (wb_win && starve != 4'(STARVE_LIMIT)) starve <= starve + 4'd1;
            wr_enable <= grant && g_addr != '0;
            if (grant) begin
                wr_addr <= g_addr;
                wr_data <= g_data;
            end
        end
    end
endmodule
